// File: rtl/imdct_window_sequencer.sv
// rtl/imdct_window_sequencer.sv - streams the 36 IMDCT sine-window coefficients of one subband block
// Window table is generated from folded quarter-wave constants (Q0.17, 1.0 = 2^17).
module imdct_sinwindow_rom #(
    parameter int COEF_WIDTH = 18
) (
    input  logic                  clk_i,
    input  logic                  rd_en_i,
    input  logic [7:0]            addr_i,
    output logic [COEF_WIDTH-1:0] data_o
);
    localparam logic [17:0] UNITY = 18'd131072;

    // round(2^17 * sin(pi*(2k+1)/72)), k = 0..17; every window is folded onto this table
    function automatic logic [17:0] quarter(input logic [4:0] k);
        case (k)
            5'd0:  quarter = 18'd5717;
            5'd1:  quarter = 18'd17108;
            5'd2:  quarter = 18'd28369;
            5'd3:  quarter = 18'd39414;
            5'd4:  quarter = 18'd50159;
            5'd5:  quarter = 18'd60522;
            5'd6:  quarter = 18'd70425;
            5'd7:  quarter = 18'd79792;
            5'd8:  quarter = 18'd88551;
            5'd9:  quarter = 18'd96636;
            5'd10: quarter = 18'd103986;
            5'd11: quarter = 18'd110545;
            5'd12: quarter = 18'd116262;
            5'd13: quarter = 18'd121095;
            5'd14: quarter = 18'd125006;
            5'd15: quarter = 18'd127965;
            5'd16: quarter = 18'd129951;
            5'd17: quarter = 18'd130947;
            default: quarter = '0;
        endcase
    endfunction

    function automatic logic [17:0] long_win(input logic [5:0] n);
        return quarter((n < 6'd18) ? n[4:0] : 5'(6'd35 - n));
    endfunction

    // sin(pi*(2k+1)/24) equals the long-table entry 3j+1 after folding k onto 0..5
    function automatic logic [17:0] short_win(input logic [3:0] k);
        logic [4:0] j;
        j = (k < 4'd6) ? {1'b0, k} : 5'(4'd11 - k);
        return quarter(5'(3 * j + 1));
    endfunction

    function automatic logic [17:0] rom_word(input logic [7:0] addr);
        logic [5:0]  n;
        logic [17:0] w;
        n = addr[5:0];
        w = '0;
        case (addr[7:6])
            2'd0: if (n < 6'd36) w = long_win(n);
            2'd1: begin
                if (n < 6'd18)      w = long_win(n);
                else if (n < 6'd24) w = UNITY;
                else if (n < 6'd30) w = short_win(4'(n - 6'd18));
            end
            2'd2: if (n < 6'd12) w = short_win(n[3:0]);
            default: begin
                if (n >= 6'd6 && n < 6'd12)       w = short_win(4'(n - 6'd6));
                else if (n >= 6'd12 && n < 6'd18) w = UNITY;
                else if (n >= 6'd18 && n < 6'd36) w = long_win(n);
            end
        endcase
        return w;
    endfunction

    logic [COEF_WIDTH-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rd_en_i) data_q <= COEF_WIDTH'(rom_word(addr_i));
    end

    assign data_o = data_q;
endmodule

module imdct_window_sequencer #(
    parameter int COEF_WIDTH = 18,
    parameter int CHANNELS   = 2,
    parameter int CH_BITS    = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  start_valid_i,
    output logic                  start_ready_o,
    input  logic [1:0]            start_type_i,
    input  logic                  start_mixed_i,
    input  logic [4:0]            start_sb_i,
    input  logic [CH_BITS-1:0]    start_ch_i,
    output logic                  coef_valid_o,
    input  logic                  coef_ready_i,
    output logic [COEF_WIDTH-1:0] coef_data_o,
    output logic [5:0]            coef_index_o,
    output logic [CH_BITS-1:0]    coef_ch_o,
    output logic                  coef_last_o,
    output logic                  seq_error_o,
    input  logic                  clear_error_i
);
    localparam int                 CH_SLOTS = 1 << CH_BITS;
    localparam logic [CH_BITS:0]   CH_LIM   = CHANNELS[CH_BITS:0];

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q;
    logic [5:0]           idx_q;
    logic [3:0]           mod12_q;
    logic [1:0]           win_q;
    logic [CH_BITS-1:0]   ch_q;
    logic                 valid_q;
    logic [5:0]           index_q;
    logic [CH_BITS-1:0]   och_q;
    logic                 last_q;
    logic                 err_q;
    logic                 err_d;
    logic [1:0]           prev_q [CH_SLOTS];

    logic       advance, issue, accept, ch_ok, legal, new_err;
    logic [1:0] eff_win, prev_type;
    logic [5:0] rom_n;

    assign advance   = !valid_q || coef_ready_i;
    assign issue     = (state_q == RUN) && advance;
    assign accept    = start_valid_i && (state_q == IDLE);
    assign ch_ok     = {1'b0, start_ch_i} < CH_LIM;
    assign prev_type = prev_q[start_ch_i];
    assign legal     = (prev_type == 2'd0 || prev_type == 2'd3) ? (start_type_i <= 2'd1)
                                                                : (start_type_i >= 2'd2);
    assign new_err   = accept && (!ch_ok || (start_sb_i == 5'd0 && !legal));
    assign err_d     = new_err ? 1'b1 : (clear_error_i ? 1'b0 : err_q);
    // Mixed short blocks use the long window for the two lowest subbands
    assign eff_win   = (start_type_i == 2'd2 && start_mixed_i && start_sb_i < 5'd2) ? 2'd0 : start_type_i;
    assign rom_n     = (win_q == 2'd2) ? {2'b00, mod12_q} : idx_q;

    imdct_sinwindow_rom #(.COEF_WIDTH(COEF_WIDTH)) u_rom (
        .clk_i   (clk_i),
        .rd_en_i (advance),
        .addr_i  ({win_q, rom_n}),
        .data_o  (coef_data_o)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mod12_q <= '0;
            win_q   <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            och_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int c = 0; c < CH_SLOTS; c++) prev_q[c] <= 2'd0;
        end else begin
            err_q <= err_d;
            if (advance) begin
                valid_q <= issue;
                last_q  <= issue && (idx_q == 6'd35);
                if (issue) begin
                    index_q <= idx_q;
                    och_q   <= ch_q;
                end
            end
            case (state_q)
                IDLE: if (accept) begin
                    state_q <= RUN;
                    idx_q   <= '0;
                    mod12_q <= '0;
                    win_q   <= eff_win;
                    ch_q    <= start_ch_i;
                    if (start_sb_i == 5'd0 && ch_ok) prev_q[start_ch_i] <= start_type_i;
                end
                default: if (advance) begin
                    idx_q   <= idx_q + 6'd1;
                    mod12_q <= (mod12_q == 4'd11) ? 4'd0 : mod12_q + 4'd1;
                    if (idx_q == 6'd35) state_q <= IDLE;
                end
            endcase
        end
    end

    assign start_ready_o = (state_q == IDLE);
    assign coef_valid_o  = valid_q;
    assign coef_index_o  = index_q;
    assign coef_ch_o     = och_q;
    assign coef_last_o   = last_q;
    assign seq_error_o   = err_q;
endmodule

// File: tb/tb_imdct_window_sequencer.sv
// tb/tb_imdct_window_sequencer.sv - scoreboard bench for imdct_window_sequencer
module tb_imdct_window_sequencer;
    localparam int CW  = 18;
    localparam int CHB = 2;

    typedef struct {
        longint data;
        int     index;
        int     ch;
        bit     last;
    } beat_t;

    beat_t sb[$];

    logic           clk, reset_n, start_valid, start_ready, start_mixed;
    logic           coef_valid, coef_ready, coef_last, seq_error, clear_error;
    logic [1:0]     start_type;
    logic [4:0]     start_sb;
    logic [CHB-1:0] start_ch, coef_ch;
    logic [CW-1:0]  coef_data;
    logic [5:0]     coef_index;

    int total, bad, cyc, accept_cyc, first_cyc, rdy_mode, stall_n;
    bit lat_pending, stalled;

    imdct_window_sequencer #(.COEF_WIDTH(CW), .CHANNELS(2), .CH_BITS(CHB)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .start_valid_i (start_valid),
        .start_ready_o (start_ready),
        .start_type_i  (start_type),
        .start_mixed_i (start_mixed),
        .start_sb_i    (start_sb),
        .start_ch_i    (start_ch),
        .coef_valid_o  (coef_valid),
        .coef_ready_i  (coef_ready),
        .coef_data_o   (coef_data),
        .coef_index_o  (coef_index),
        .coef_ch_o     (coef_ch),
        .coef_last_o   (coef_last),
        .seq_error_o   (seq_error),
        .clear_error_i (clear_error)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint exp_coef(input int w, input int n);
        real pi, x;
        pi = 3.14159265358979;
        case (w)
            0: x = $sin(pi * (n + 0.5) / 36.0);
            1: x = (n < 18) ? $sin(pi * (n + 0.5) / 36.0) : (n < 24) ? 1.0 :
                   (n < 30) ? $sin(pi * (n - 18 + 0.5) / 12.0) : 0.0;
            2: x = $sin(pi * (n + 0.5) / 12.0);
            default: x = (n < 6) ? 0.0 : (n < 12) ? $sin(pi * (n - 6 + 0.5) / 12.0) :
                         (n < 18) ? 1.0 : $sin(pi * (n + 0.5) / 36.0);
        endcase
        return longint'($rtoi(x * 131072.0 + 0.5));
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Downstream ready pattern: 0 always, 1 toggling, 2 one 5-cycle stall at index 17
    initial begin
        coef_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: coef_ready = ~coef_ready;
                2: begin
                    if (stall_n > 0) begin
                        coef_ready = 0;
                        stall_n--;
                    end else if (!stalled && coef_valid && coef_index == 6'd17) begin
                        coef_ready = 0;
                        stall_n = 4;
                        stalled = 1;
                    end else begin
                        coef_ready = 1;
                    end
                end
                default: coef_ready = 1;
            endcase
        end
    end

    initial begin
        beat_t  e;
        longint d;
        forever begin
            @(negedge clk);
            if (reset_n && coef_valid) begin
                if (sb.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = sb[0];
                    d = longint'(coef_data);
                    if (d - e.data <= 2 && e.data - d <= 2) d = e.data;
                    check("data", d, e.data);
                    check("index", coef_index, e.index);
                    check("ch", coef_ch, e.ch);
                    check("last", coef_last, e.last);
                    if (lat_pending && e.index == 0) begin
                        check("latency", cyc - accept_cyc, 2);
                        lat_pending = 0;
                        first_cyc = cyc;
                    end
                    if (coef_ready) begin
                        if (e.last && rdy_mode == 0) check("gapfree", cyc - first_cyc, 35);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input logic [1:0] t, input logic m, input logic [4:0] s, input logic [CHB-1:0] c);
        int    w, n;
        beat_t e;
        @(posedge clk);
        #1;
        start_type = t; start_mixed = m; start_sb = s; start_ch = c; start_valid = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!start_ready && n < 200);
        check("accepted", start_ready, 1);
        w = (t == 2'd2 && m && s < 5'd2) ? 0 : int'(t);
        for (int i = 0; i < 36; i++) begin
            e.data  = exp_coef(w, (w == 2) ? i % 12 : i);
            e.index = i;
            e.ch    = int'(c);
            e.last  = (i == 35);
            sb.push_back(e);
        end
        accept_cyc  = cyc;
        lat_pending = 1;
        @(posedge clk);
        #1;
        start_valid = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drained", sb.size(), 0);
        @(negedge clk);
        check("idle_valid", coef_valid, 0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_error = 1;
        @(negedge clk);
        clear_error = 0;
    endtask

    initial begin
        int n;
        total = 0; bad = 0; rdy_mode = 0; stall_n = 0; stalled = 0; lat_pending = 0;
        reset_n = 0; start_valid = 0; start_type = 0; start_mixed = 0; start_sb = 0;
        start_ch = 0; clear_error = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        @(negedge clk);
        check("rst_ready", start_ready, 1);
        check("rst_valid", coef_valid, 0);
        check("rst_err", seq_error, 0);
        check("rst_index", coef_index, 0);
        check("rst_last", coef_last, 0);

        send(2'd0, 0, 5'd0, 2'd0);
        drain();
        check("err_normal", seq_error, 0);
        send(2'd2, 0, 5'd5, 2'd1);
        drain();
        send(2'd0, 0, 5'd3, 2'd0);
        send(2'd1, 0, 5'd3, 2'd1);
        drain();
        send(2'd2, 1, 5'd1, 2'd0);
        send(2'd2, 1, 5'd2, 2'd0);
        drain();

        rdy_mode = 1;
        send(2'd3, 0, 5'd7, 2'd1);
        drain();
        stalled = 0; rdy_mode = 2;
        send(2'd0, 0, 5'd9, 2'd0);
        drain();
        check("stall_seen", stalled, 1);
        rdy_mode = 0;
        check("err_before_seq", seq_error, 0);

        send(2'd0, 0, 5'd0, 2'd0);
        drain();
        check("err_0_to_0", seq_error, 0);
        send(2'd2, 0, 5'd0, 2'd0);
        drain();
        check("err_0_to_2", seq_error, 1);
        pulse_clear();
        check("err_cleared", seq_error, 0);
        send(2'd1, 0, 5'd0, 2'd1);
        drain();
        check("err_ch1_indep", seq_error, 0);
        send(2'd3, 0, 5'd0, 2'd0);
        drain();
        check("err_2_to_3", seq_error, 0);
        send(2'd2, 0, 5'd6, 2'd0);
        drain();
        check("err_sb_nonzero", seq_error, 0);
        send(2'd0, 0, 5'd0, 2'd2);
        drain();
        check("err_bad_ch", seq_error, 1);

        send(2'd2, 0, 5'd0, 2'd0);
        drain();
        send(2'd0, 0, 5'd4, 2'd0);
        n = 0;
        while (!(coef_valid && coef_index == 6'd20) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_idx20", coef_index, 20);
        reset_n = 0;
        @(posedge clk);
        #1;
        reset_n = 1;
        sb.delete();
        lat_pending = 0;
        check("mid_rst_valid", coef_valid, 0);
        check("mid_rst_ready", start_ready, 1);
        check("mid_rst_err", seq_error, 0);
        send(2'd0, 0, 5'd0, 2'd0);
        drain();
        check("err_after_rst", seq_error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
